mem_access_unit: RTL

Initiator-side load/store engine that drives the 16-bit byte-addressed data memory on behalf of the CPU execute stage. It accepts one load or store request at a time over a valid/ready handshake. Supported accesses are byte and word, signed or unsigned, aligned or unaligned. It sequences the memory's word-granular port (read-modify-write for byte stores, split accesses for unaligned words) and returns one response pulse per request.

---
 rtl/memacc_pkg.sv | 19 +
 rtl/byte_lane_merge.sv | 26 ++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/memacc_pkg.sv
// memacc_pkg: shared types and constants for the memory access unit.
//   state_t     - FSM state encoding (IDLE, RD0, WR0, RD1, WR1, RESP)
//   ADDR_W_DEF  - default byte address width
//   LANE_LO/HI  - byte lane select (even address = low lane, odd = high lane)
package memacc_pkg;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR1  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: combinational byte lane helper.
//   i_word/i_ins_lane/i_ins_byte -> o_word : i_word with one lane replaced
//   i_src/i_ext_lane/i_signed    -> o_ext  : one lane of i_src, zero/sign extended
module byte_lane_merge
  import memacc_pkg::*;
(
  input  logic [15:0] i_word,
  input  logic        i_ins_lane,
  input  logic [7:0]  i_ins_byte,
  output logic [15:0] o_word,
  input  logic [15:0] i_src,
  input  logic        i_ext_lane,
  input  logic        i_signed,
  output logic [15:0] o_ext
);
  logic [7:0] w_ext_byte;

  always_comb begin
    o_word = i_word;
    if (i_ins_lane == LANE_HI) o_word[15:8] = i_ins_byte;
    else                       o_word[7:0]  = i_ins_byte;
  end

  assign w_ext_byte = (i_ext_lane == LANE_HI) ? i_src[15:8] : i_src[7:0];
  assign o_ext      = {{8{i_signed & w_ext_byte[7]}}, w_ext_byte};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store engine driving a word-granular, byte-addressed
// 16-bit data memory. One request at a time (valid/ready), one resp pulse each.
// Byte stores are read-modify-write; unaligned words split into two word accesses.
//   Request : req_valid, req_ready, req_we, req_byte, req_signed, req_addr, req_wdata
//   Response: resp_valid (1-cycle pulse), resp_rdata, resp_err
//   Memory  : addrm (even word address), wmdata, re, we, rwdata (comb read data)
// Optional feature macro MEMACC_ALIGN_TRAP_EN: unaligned word accesses are
// rejected with resp_err=1 and no memory traffic instead of being split.
module mem_access_unit
  import memacc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addrm,
  output logic [15:0]       wmdata,
  output logic              re,
  output logic              we,
  input  logic [15:0]       rwdata
);
  state_t            r_state, w_next;
  logic              r_we, r_byte, r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata, r_buf;
  logic              r_resp_valid;
  logic [15:0]       r_resp_rdata;
  logic [ADDR_W-1:0] w_addr0, w_addr1;
  logic              w_unal, w_req_trap;
  logic              w_ins_lane;
  logic [7:0]        w_ins_byte;
  logic [15:0]       w_merged, w_ext;

  assign w_addr0   = {r_addr[ADDR_W-1:1], 1'b0};
  assign w_addr1   = w_addr0 + ADDR_W'(2);   // wraps past top of memory
  assign w_unal    = ~r_byte & r_addr[0];
  assign req_ready = (r_state == S_IDLE);

`ifdef MEMACC_ALIGN_TRAP_EN
  logic r_resp_err;
  assign w_req_trap = ~req_byte & req_addr[0];
  assign resp_err   = r_resp_err;
`else
  assign w_req_trap = 1'b0;
  assign resp_err   = 1'b0;
`endif

  // WR1 carries the high data byte into the low lane of the second word;
  // WR0 carries the low data byte into the lane picked by addr[0].
  assign w_ins_lane = (r_state == S_WR1) ? LANE_LO : r_addr[0];
  assign w_ins_byte = (r_state == S_WR1) ? r_wdata[15:8] : r_wdata[7:0];

  byte_lane_merge u_merge (
    .i_word     (r_buf),
    .i_ins_lane (w_ins_lane),
    .i_ins_byte (w_ins_byte),
    .o_word     (w_merged),
    .i_src      (rwdata),
    .i_ext_lane (r_addr[0]),
    .i_signed   (r_signed),
    .o_ext      (w_ext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    re     = 1'b0;
    we     = 1'b0;
    addrm  = '0;
    wmdata = '0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        if (w_req_trap)                            w_next = S_RESP;
        else if (req_we & ~req_byte & ~req_addr[0]) w_next = S_WR0;
        else                                       w_next = S_RD0;
      end
      S_RD0: begin
        re    = 1'b1;
        addrm = w_addr0;
        if (r_we)        w_next = S_WR0;
        else if (w_unal) w_next = S_RD1;
        else             w_next = S_RESP;
      end
      S_WR0: begin
        we     = 1'b1;
        addrm  = w_addr0;
        wmdata = (~r_byte & ~r_addr[0]) ? r_wdata : w_merged;
        w_next = w_unal ? S_RD1 : S_RESP;
      end
      S_RD1: begin
        re     = 1'b1;
        addrm  = w_addr1;
        w_next = r_we ? S_WR1 : S_RESP;
      end
      S_WR1: begin
        we     = 1'b1;
        addrm  = w_addr1;
        wmdata = w_merged;
        w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_byte       <= 1'b0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_buf        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
`ifdef MEMACC_ALIGN_TRAP_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      if (req_valid && r_state == S_IDLE) begin
        r_we     <= req_we;
        r_byte   <= req_byte;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (re) r_buf <= rwdata;
      r_resp_valid <= (w_next == S_RESP);
      if (w_next == S_RESP) begin
        // Leaving IDLE straight into RESP only happens for a trapped access.
        if (r_state == S_IDLE || r_we) r_resp_rdata <= '0;
        else if (r_state == S_RD1)     r_resp_rdata <= {rwdata[7:0], r_buf[15:8]};
        else if (r_byte)               r_resp_rdata <= w_ext;
        else                           r_resp_rdata <= rwdata;
`ifdef MEMACC_ALIGN_TRAP_EN
        r_resp_err <= (r_state == S_IDLE);
`endif
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
endmodule
